// File: rtl/alu_result_fifo.sv
// alu_result_fifo
//   Result buffer behind the arithmetic unit. Every In_Data word qualified by
//   In_Valid (the unit's Arith_Flag) is captured into a DEPTH-entry
//   first-word-fall-through FIFO. The consumer drains it over a valid/ready
//   handshake. The ALU is never stalled: a write that arrives while the FIFO
//   is full and nothing is being drained is discarded and counted.
//
// Optional feature: define RESULT_FLAGS_EN to store a zero flag and a sign
// flag with each entry and present them on Out_Zero / Out_Neg.
//
// Ports
//   CLK        rising-edge clock
//   RST        asynchronous active-low reset
//   In_Data    signed result from the arithmetic unit
//   In_Valid   write request
//   Out_Data   head entry, 0 while Empty
//   Out_Valid  head entry available (= !Empty)
//   Out_Ready  consumer accepts the head this cycle
//   Full       DEPTH entries held
//   Empty      no entries held
//   Level      number of entries held, 0..DEPTH
//   Drop_Err   one-cycle pulse after a rejected write
//   Drop_Count saturating count of rejected writes
//   Out_Zero   head == 0        (RESULT_FLAGS_EN only)
//   Out_Neg    head sign bit    (RESULT_FLAGS_EN only)
module alu_result_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] In_Data,
  input  logic                  In_Valid,
  output logic [DATA_WIDTH-1:0] Out_Data,
  output logic                  Out_Valid,
  input  logic                  Out_Ready,
  output logic                  Full,
  output logic                  Empty,
  output logic [ADDR_WIDTH:0]   Level,
`ifdef RESULT_FLAGS_EN
  output logic                  Out_Zero,
  output logic                  Out_Neg,
`endif
  output logic                  Drop_Err,
  output logic [7:0]            Drop_Count
);

  // Pointers carry one wrap bit above the address so full and empty differ.
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic pop;
  logic push;
  logic drop;

  assign Empty     = (wr_ptr == rd_ptr);
  assign Full      = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                     (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign Level     = wr_ptr - rd_ptr;
  assign Out_Valid = !Empty;

  assign pop  = Out_Valid && Out_Ready;
  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign push = In_Valid && (!Full || pop);
  assign drop = In_Valid && Full && !pop;

  assign Out_Data = Empty ? '0 : mem[rd_ptr[ADDR_WIDTH-1:0]];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      Drop_Err   <= 1'b0;
      Drop_Count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      Drop_Err <= drop;
      if (drop && (Drop_Count != 8'hFF)) Drop_Count <= Drop_Count + 8'd1;
    end
  end

  // Storage is deliberately not reset; the pointers alone define validity.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr[ADDR_WIDTH-1:0]] <= In_Data;
  end

`ifdef RESULT_FLAGS_EN
  logic zero_mem [DEPTH];
  logic neg_mem  [DEPTH];

  always_ff @(posedge CLK) begin
    if (push) begin
      zero_mem[wr_ptr[ADDR_WIDTH-1:0]] <= (In_Data == '0);
      neg_mem[wr_ptr[ADDR_WIDTH-1:0]]  <= In_Data[DATA_WIDTH-1];
    end
  end

  assign Out_Zero = Empty ? 1'b0 : zero_mem[rd_ptr[ADDR_WIDTH-1:0]];
  assign Out_Neg  = Empty ? 1'b0 : neg_mem[rd_ptr[ADDR_WIDTH-1:0]];
`endif

endmodule
